// File: rtl/ex_mul_div_pkg.sv
// Shared types, function codes and helpers for the EX-stage multiply/divide unit.
package ex_mul_div_pkg;

    typedef logic [31:0] data_bus_t;
    typedef logic [5:0]  funct_bus_t;
    typedef logic [63:0] double_data_bus_t;

    localparam funct_bus_t FUNCT_MULT  = 6'h18;
    localparam funct_bus_t FUNCT_MULTU = 6'h19;
    localparam funct_bus_t FUNCT_DIV   = 6'h1A;
    localparam funct_bus_t FUNCT_DIVU  = 6'h1B;

    function automatic logic is_muldiv(input funct_bus_t f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    function automatic data_bus_t neg_if(input logic neg, input data_bus_t v);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/ex_mul_div_if.sv
// EX-stage request/result bundle between the pipeline (master) and the mul/div unit (slave).
interface ex_mul_div_if;

    logic                         flush;
    logic                         start;
    ex_mul_div_pkg::funct_bus_t   funct;
    ex_mul_div_pkg::data_bus_t    operand_1;
    ex_mul_div_pkg::data_bus_t    operand_2;
    logic                         busy;
    logic                         done;
    ex_mul_div_pkg::data_bus_t    hi;
    ex_mul_div_pkg::data_bus_t    lo;

    modport master (
        output flush, start, funct, operand_1, operand_2,
        input  busy, done, hi, lo
    );

    modport slave (
        input  flush, start, funct, operand_1, operand_2,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/ex_mul_div_div_core.sv
// 32-step radix-2 restoring divider on unsigned magnitudes; one quotient bit per step.
module ex_mul_div_div_core
    import ex_mul_div_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  logic      step,
    input  data_bus_t dividend,
    input  data_bus_t divisor,
    output data_bus_t quotient,
    output data_bus_t remainder,
    output logic      fin
);

    logic [5:0]  cnt_q, cnt_d;
    data_bus_t   rem_q, rem_d;
    data_bus_t   dvd_q, dvd_d;
    data_bus_t   dsr_q, dsr_d;
    data_bus_t   quo_q, quo_d;
    logic [32:0] shifted_s;
    logic [33:0] diff_s;

    // Next-state for one restoring step, or a fresh load on start.
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        quo_d     = quo_q;
        shifted_s = {rem_q, dvd_q[31]};
        diff_s    = {1'b0, shifted_s} - {2'b00, dsr_q};
        if (start) begin
            cnt_d = 6'd0;
            rem_d = 32'd0;
            dvd_d = dividend;
            dsr_d = divisor;
            quo_d = 32'd0;
        end else if (step) begin
            dvd_d = {dvd_q[30:0], 1'b0};
            cnt_d = cnt_q + 6'd1;
            // A borrow means the divisor did not fit: restore (keep the shifted value).
            if (diff_s[33]) begin
                rem_d = shifted_s[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end else begin
                rem_d = diff_s[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 6'd0;
            rem_q <= 32'd0;
            dvd_q <= 32'd0;
            dsr_q <= 32'd0;
            quo_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            dsr_q <= dsr_d;
            quo_q <= quo_d;
        end
    end

    assign fin       = step & (cnt_q == 6'd31);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_mul_div.sv
// EX-stage iterative multiply/divide: 2-cycle multiply, 34-cycle restoring divide, HI/LO result.
module ex_mul_div
    import ex_mul_div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    ex_mul_div_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DATA_WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d;
    logic                    signed_q, signed_d;
    logic                    neg_quo_q, neg_quo_d;
    logic                    neg_rem_q, neg_rem_d;

    logic                    core_start_s, core_step_s, core_fin_s;
    data_bus_t               core_quo_s, core_rem_s;
    data_bus_t               abs_1_s, abs_2_s;
    logic                    sign_1_s, sign_2_s, op_signed_s;
    double_data_bus_t        mul_a_s, mul_b_s, product_s;

    ex_mul_div_div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start_s),
        .step      (core_step_s),
        .dividend  (abs_1_s),
        .divisor   (abs_2_s),
        .quotient  (core_quo_s),
        .remainder (core_rem_s),
        .fin       (core_fin_s)
    );

    // Sign extension to 64 bits makes one unsigned multiply exact for both MULT and MULTU.
    always_comb begin
        op_signed_s = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
        sign_1_s    = op_signed_s & bus.operand_1[31];
        sign_2_s    = op_signed_s & bus.operand_2[31];
        abs_1_s     = neg_if(sign_1_s, bus.operand_1);
        abs_2_s     = neg_if(sign_2_s, bus.operand_2);
        mul_a_s     = {{32{signed_q & op1_q[31]}}, op1_q};
        mul_b_s     = {{32{signed_q & op2_q[31]}}, op2_q};
        product_s   = mul_a_s * mul_b_s;
    end

    // Control FSM: next state, operand capture and result formation.
    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        hi_d         = hi_q;
        lo_d         = lo_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        signed_d     = signed_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        core_start_s = 1'b0;
        core_step_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (bus.start && is_muldiv(bus.funct)) begin
                    op1_d     = bus.operand_1;
                    op2_d     = bus.operand_2;
                    signed_d  = op_signed_s;
                    neg_quo_d = sign_1_s ^ sign_2_s;
                    neg_rem_d = sign_1_s;
                    if ((bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU)) begin
                        core_start_s = 1'b1;
                        state_d      = S_DIV;
                    end else begin
                        state_d = S_MUL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    {hi_d, lo_d} = product_s;
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DIV: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    core_step_s = 1'b1;
                    if (core_fin_s) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_FIX: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    // Divide by zero returns all-ones quotient and the untouched dividend.
                    if (op2_q == 32'd0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = op1_q;
                    end else begin
                        lo_d = neg_if(neg_quo_q, core_quo_s);
                        hi_d = neg_if(neg_rem_q, core_rem_s);
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            op1_q     <= 32'd0;
            op2_q     <= 32'd0;
            signed_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            signed_q  <= signed_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign bus.busy = bus.start & is_muldiv(bus.funct) & (state_q != S_DONE) & rst;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
